// File: rtl/note_sequencer.sv
// Maps keyboard bytes to notes, queues up to 4, plays each for NOTE_CYCLES then GAP_CYCLES silence.
// Byte sampled at T is visible in the queue at T; from idle the tone starts after T+1. A full queue drops the byte and pulses drop.
module note_sequencer #(
   parameter int unsigned NOTE_CYCLES = 12_500_000,
   parameter int unsigned GAP_CYCLES  = 500_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  data,
   input  logic        data_valid,
   output logic [16:0] half_period,
   output logic        tone_en,
   output logic        busy,
   output logic        drop
);
   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   localparam logic [23:0] NOTE_LOAD = 24'(NOTE_CYCLES - 1);
   localparam logic [23:0] GAP_LOAD  = 24'(GAP_CYCLES - 1);
   localparam logic [3:0]  REST_CODE = 4'd8;

   state_t      r_state, w_state_nxt;
   logic [23:0] r_cnt, w_cnt_nxt;
   logic [3:0]  r_mem [4];
   logic [1:0]  r_wptr, r_rptr;
   logic [2:0]  r_count;
   logic [16:0] r_half_period, w_hp_nxt;
   logic        r_tone_en, w_tone_nxt;
   logic        r_drop;
   logic        w_is_note, w_is_flush, w_full, w_push, w_pop;
   logic [3:0]  w_code, w_head;

   function automatic logic [16:0] note_half_period(input logic [3:0] code);
      logic [16:0] hp;
      case (code)
         4'd0:    hp = 17'd95556;
         4'd1:    hp = 17'd85131;
         4'd2:    hp = 17'd75843;
         4'd3:    hp = 17'd71586;
         4'd4:    hp = 17'd63776;
         4'd5:    hp = 17'd56818;
         4'd6:    hp = 17'd50619;
         4'd7:    hp = 17'd47778;
         default: hp = 17'd0;
      endcase
      return hp;
   endfunction

   always_comb begin
      w_is_note = 1'b1;
      w_code    = 4'd0;
      case (data)
         8'h61:   w_code = 4'd0;
         8'h73:   w_code = 4'd1;
         8'h64:   w_code = 4'd2;
         8'h66:   w_code = 4'd3;
         8'h67:   w_code = 4'd4;
         8'h68:   w_code = 4'd5;
         8'h6A:   w_code = 4'd6;
         8'h6B:   w_code = 4'd7;
         8'h20:   w_code = REST_CODE;
         default: w_is_note = 1'b0;
      endcase
   end

   // Full is judged on the pre-pop count, so a byte arriving as the head pops is still dropped.
   assign w_is_flush = data_valid && (data == 8'h78);
   assign w_full     = (r_count == 3'd4);
   assign w_push     = data_valid && w_is_note && !w_full;
   assign w_head     = r_mem[r_rptr];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tone_nxt  = r_tone_en;
      w_hp_nxt    = r_half_period;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: w_pop = (r_count != 3'd0);
         PLAY: begin
            if (r_cnt == 24'd0) begin
               w_state_nxt = GAP;
               w_cnt_nxt   = GAP_LOAD;
               w_tone_nxt  = 1'b0;
               w_hp_nxt    = 17'd0;
            end else begin
               w_cnt_nxt = r_cnt - 24'd1;
            end
         end
         GAP: begin
            if (r_cnt == 24'd0) begin
               if (r_count != 3'd0) w_pop = 1'b1;
               else                 w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 24'd1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_pop) begin
         w_state_nxt = PLAY;
         w_cnt_nxt   = NOTE_LOAD;
         w_tone_nxt  = (w_head != REST_CODE);
         w_hp_nxt    = note_half_period(w_head);
      end
      if (w_is_flush) begin
         w_pop       = 1'b0;
         w_state_nxt = IDLE;
         w_cnt_nxt   = 24'd0;
         w_tone_nxt  = 1'b0;
         w_hp_nxt    = 17'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_cnt         <= 24'd0;
         r_tone_en     <= 1'b0;
         r_half_period <= 17'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_tone_en     <= w_tone_nxt;
         r_half_period <= w_hp_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= 2'd0;
         r_rptr  <= 2'd0;
         r_count <= 3'd0;
         r_drop  <= 1'b0;
      end else begin
         r_drop <= data_valid && w_is_note && w_full;
         if (w_is_flush) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
         end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 3'd1;
               2'b01:   r_count <= r_count - 3'd1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_code;
   end

   assign half_period = r_half_period;
   assign tone_en     = r_tone_en;
   assign drop        = r_drop;
   assign busy        = (r_state != IDLE) || (r_count != 3'd0);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a timeline-based model (queue plus note start edge) checked every cycle,
// with directed scenarios pinned by literal expectations, then randomized byte traffic.
module tb_note_sequencer;
   localparam int N = 8;
   localparam int G = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  data;
   logic        data_valid;
   logic [16:0] half_period;
   logic        tone_en;
   logic        busy;
   logic        drop;

   int checks = 0;
   int errors = 0;
   int drop_seen = 0;
   bit cmp_en = 1'b0;

   int hp_tab [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};
   int burst_hp [5] = '{95556, 85131, 75843, 71586, 63776};
   logic [7:0] keys [9] = '{8'h61, 8'h73, 8'h64, 8'h66, 8'h67, 8'h68, 8'h6A, 8'h6B, 8'h20};

   // Model state: pending codes, edge at which the current note started (-1 when idle).
   int q [$];
   int cur_start;
   int cur_code;
   int ecnt;
   bit exp_tone, exp_busy, exp_drop;
   int exp_hp;

   note_sequencer #(.NOTE_CYCLES(N), .GAP_CYCLES(G)) dut (
      .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
      .half_period(half_period), .tone_en(tone_en), .busy(busy), .drop(drop)
   );

   always #5 clk = ~clk;

   function automatic int key_code(input logic [7:0] b);
      case (b)
         8'h61: return 0;
         8'h73: return 1;
         8'h64: return 2;
         8'h66: return 3;
         8'h67: return 4;
         8'h68: return 5;
         8'h6A: return 6;
         8'h6B: return 7;
         8'h20: return 8;
         default: return -1;
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin : model
      int code, pre;
      if (!rst_n) begin
         q.delete();
         cur_start = -1;
         cur_code  = 0;
         ecnt      = 0;
         exp_tone  = 0;
         exp_busy  = 0;
         exp_drop  = 0;
         exp_hp    = 0;
      end else begin
         ecnt++;
         pre      = q.size();
         code     = key_code(data);
         exp_drop = 0;
         if (data_valid && data == 8'h78) begin
            q.delete();
            cur_start = -1;
         end else begin
            if (cur_start < 0 || ecnt - cur_start >= N + G) begin
               if (pre > 0) begin
                  cur_code  = q.pop_front();
                  cur_start = ecnt;
               end else begin
                  cur_start = -1;
               end
            end
            if (data_valid && code >= 0) begin
               if (pre == 4) exp_drop = 1;
               else          q.push_back(code);
            end
         end
         exp_busy = (cur_start >= 0) || (q.size() > 0);
         if (cur_start >= 0 && ecnt - cur_start < N && cur_code != 8) begin
            exp_tone = 1;
            exp_hp   = hp_tab[cur_code];
         end else begin
            exp_tone = 0;
            exp_hp   = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         if (!rst_n) begin
            chk("rst_tone_en", tone_en, 0);
            chk("rst_half_period", half_period, 0);
            chk("rst_busy", busy, 0);
            chk("rst_drop", drop, 0);
         end else begin
            chk("tone_en", tone_en, exp_tone);
            chk("half_period", half_period, exp_hp);
            chk("busy", busy, exp_busy);
            chk("drop", drop, exp_drop);
         end
         if (drop) drop_seen++;
      end
   end

   // Called at a negedge; returns at the next negedge with the byte sampled (ecnt == sampling edge).
   task automatic drive(input logic [7:0] b);
      data = b;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic wait_to(input int target);
      while (ecnt < target) @(negedge clk);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300 && busy; i++) @(negedge clk);
      chk("idle_reached", busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int t, on, gap, d0;
      rst_n = 1'b0;
      data = 8'h00;
      data_valid = 1'b0;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_tone", tone_en, 0);
      chk("reset_hp", half_period, 0);
      chk("reset_busy", busy, 0);
      chk("reset_drop", drop, 0);

      // Single 'h'
      d0 = drop_seen;
      drive(8'h68);
      t = ecnt;
      chk("h_queued_busy", busy, 1);
      chk("h_not_yet_tone", tone_en, 0);
      wait_to(t + 1);
      chk("h_tone", tone_en, 1);
      chk("h_hp", half_period, 56818);
      on = 0;
      for (int i = 0; i < 30 && tone_en; i++) begin
         on++;
         @(negedge clk);
      end
      chk("h_on_cycles", on, N);
      gap = 0;
      for (int i = 0; i < 30 && busy && !tone_en; i++) begin
         gap++;
         @(negedge clk);
      end
      chk("h_gap_cycles", gap, G);
      chk("h_busy_after_gap", busy, 0);
      chk("h_no_drop", drop_seen - d0, 0);

      // Burst of five while idle
      d0 = drop_seen;
      drive(8'h61);
      t = ecnt;
      drive(8'h73);
      drive(8'h64);
      drive(8'h66);
      drive(8'h67);
      for (int k = 0; k < 5; k++) begin
         wait_to(t + 1 + k * (N + G));
         chk("burst_hp", half_period, burst_hp[k]);
         chk("burst_tone", tone_en, 1);
      end
      wait_idle();
      chk("burst_no_drop", drop_seen - d0, 0);

      // Overflow while a note plays
      drive(8'h68);
      t = ecnt;
      wait_to(t + 2);
      d0 = drop_seen;
      drive(8'h61);
      drive(8'h73);
      drive(8'h64);
      drive(8'h66);
      drive(8'h67);
      drive(8'h68);
      @(negedge clk);
      @(negedge clk);
      chk("overflow_drops", drop_seen - d0, 2);
      for (int k = 0; k < 4; k++) begin
         wait_to(t + 1 + (k + 1) * (N + G));
         chk("overflow_hp", half_period, burst_hp[k]);
      end
      wait_idle();

      // Note, rest, note
      drive(8'h68);
      t = ecnt;
      drive(8'h20);
      drive(8'h68);
      wait_to(t + 1);
      chk("hrh_first", half_period, 56818);
      wait_to(t + 1 + (N + G));
      chk("hrh_rest_tone", tone_en, 0);
      chk("hrh_rest_hp", half_period, 0);
      chk("hrh_rest_busy", busy, 1);
      wait_to(t + 1 + 2 * (N + G));
      chk("hrh_last_tone", tone_en, 1);
      chk("hrh_last_hp", half_period, 56818);
      wait_idle();

      // Mid-note flush
      drive(8'h6B);
      t = ecnt;
      drive(8'h6A);
      drive(8'h6A);
      drive(8'h78);
      chk("flush_edge", ecnt, t + 3);
      chk("flush_tone", tone_en, 0);
      chk("flush_hp", half_period, 0);
      chk("flush_busy", busy, 0);
      repeat (30) @(negedge clk);
      chk("flush_silent", tone_en, 0);
      chk("flush_still_idle", busy, 0);

      // Ignored bytes, then async reset mid-note
      d0 = drop_seen;
      drive(8'h51);
      drive(8'h0D);
      @(negedge clk);
      chk("ignored_busy", busy, 0);
      chk("ignored_tone", tone_en, 0);
      chk("ignored_drop", drop_seen - d0, 0);
      drive(8'h61);
      t = ecnt;
      wait_to(t + 4);
      chk("pre_reset_tone", tone_en, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_tone", tone_en, 0);
      chk("async_rst_hp", half_period, 0);
      chk("async_rst_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive(8'h61);
      t = ecnt;
      wait_to(t + 1);
      chk("post_reset_tone", tone_en, 1);
      chk("post_reset_hp", half_period, 95556);
      wait_idle();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 3) == 0) begin
            if (r < 72)      data = keys[$urandom_range(0, 8)];
            else if (r < 75) data = 8'h78;
            else             data = 8'($urandom_range(0, 255));
            data_valid = 1'b1;
         end else begin
            data_valid = 1'b0;
         end
         @(negedge clk);
      end
      data_valid = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Sits between uart_rx and the tone generator.
- Consumes received bytes (data/data_valid), maps ASCII keyboard keys to musical notes and queues them in a 4-entry FIFO.
- Plays each note for a fixed duration, followed by a short silent gap, by driving a half-period count and enable to the tone generator.
- Flags dropped bytes and exposes a busy status.

Parameters:
- NOTE_CYCLES, 12_500_000, clocks a note (or rest) is held: 250 ms at 50 MHz. Range 2..2^24-1.
- GAP_CYCLES, 500_000, silent clocks after every note/rest: 10 ms at 50 MHz. Range 1..2^24-1.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- data  input  8  received byte from uart_rx.
- data_valid  input  1  one-cycle strobe, data valid.
- half_period  output  17  tone generator half-period count in clk cycles; 0 when silent.
- tone_en  output  1  tone generator enable.
- busy  output  1  high when state != IDLE or FIFO non-empty.
- drop  output  1  one-cycle pulse when a valid note byte is discarded because the FIFO is full.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, state IDLE, counters 0.
- Key map (fixed, 50 MHz clock), byte -> half_period:
  - 'a' 0x61 -> 95556 (C4)
  - 's' 0x73 -> 85131 (D4)
  - 'd' 0x64 -> 75843 (E4)
  - 'f' 0x66 -> 71586 (F4)
  - 'g' 0x67 -> 63776 (G4)
  - 'h' 0x68 -> 56818 (A4)
  - 'j' 0x6A -> 50619 (B4)
  - 'k' 0x6B -> 47778 (C5)
  - ' ' 0x20 -> rest, code 8
- Control byte: 'x' 0x78 = flush.
- All other bytes are ignored: no FIFO write, no drop.
- FIFO:
  - 4 entries × 4-bit note code (0..7 notes, 8 rest).
  - Write pointer, read pointer and a 3-bit count; pointers wrap modulo 4.
  - Push: on a clk edge where data_valid=1 and the byte is a mapped key.
  - Full is evaluated before that cycle's pop. Full -> byte discarded, drop=1 for exactly the next cycle, FIFO unchanged.
  - Simultaneous push and pop when not full: both take effect, count unchanged.
- Flush ('x' with data_valid):
  - Empties the FIFO.
  - Forces state to IDLE and tone_en=0, half_period=0 on the following edge.
  - Flush wins over a pop in the same cycle.
- FSM states IDLE, PLAY, GAP:
  - IDLE: when FIFO non-empty, pop the head. Load the counter with NOTE_CYCLES-1 and go to PLAY. Registered on the same edge: if the note code is 0..7, tone_en=1 and half_period=table value; if rest, tone_en=0 and half_period=0.
  - PLAY: counter decrements each cycle. At 0: tone_en=0, half_period=0, counter=GAP_CYCLES-1, go to GAP.
  - GAP: counter decrements. At 0: if FIFO non-empty, pop and enter PLAY directly on the same edge (same load rules as IDLE); else go to IDLE.
- Timing:
  - Latency: data_valid sampled at edge T, entry visible at T; from IDLE, tone_en rises after edge T+1.
  - A note occupies exactly NOTE_CYCLES cycles with tone_en=1, then exactly GAP_CYCLES cycles with tone_en=0.
  - Back-to-back notes: period NOTE_CYCLES+GAP_CYCLES, no extra IDLE cycle.
- Reset mid-note: outputs drop to 0 immediately (async), FIFO cleared.
- Bytes arriving during PLAY/GAP are queued normally; the current note is never interrupted except by flush or reset.

Test Plan (NOTE_CYCLES=8, GAP_CYCLES=2 in bench):
- Reset then single 'h': valid at edge T -> tone_en=1, half_period=56818 from T+1 for 8 cycles, then 0 for 2 cycles, busy falls after the gap, drop never asserted.
- Burst 'a','s','d','f','g' on consecutive cycles while IDLE: 'a' pops at T+1, leaving space, so all 5 are accepted, no drop. Notes play 95556, 85131, 75843, 71586, 63776, each 8 on / 2 off, no IDLE cycles between them.
- During a playing note, send 'a','s','d','f','g','h': first 4 queued, the 5th and 6th each produce a one-cycle drop pulse. Queue plays C4, D4, E4, F4 afterwards.
- 'h',' ','h': A4 for 8 cycles, gap 2, rest (tone_en=0, half_period=0) for 8 cycles, gap 2, A4 for 8 cycles.
- Mid-note flush: 'k','j','j', then 'x' at cycle 3 of 'k' -> tone_en=0 and half_period=0 on the next edge, busy=0, and nothing further plays.
- Ignored bytes and reset: 'Q' and 0x0D -> no output change and no drop. rst_n pulled low mid-note -> outputs 0 without a clock edge. After release, a new 'a' plays normally.
